textmode_attr: RTL and testbench
================================

TEXTMODE_ATTR -- requirements
Module: textmode_attr

Interface
REQ-001 The block SHALL have parameter CORDW, default 16, signed coordinate width.
REQ-002 The block SHALL have parameter WORD, default 32, tram word width.
REQ-003 The block SHALL have parameter ADDRW, default 11, tram address width.
REQ-004 The block SHALL have parameter TRAM_DEPTH, default 2016, valid tram words (<=2^ADDRW).
REQ-005 The block SHALL have parameter CIDXW, default 4, colour index width.
REQ-006 The block SHALL have parameter GLYPH_W, default 8, glyph width in pixels.
REQ-007 The block SHALL have parameter GLYPH_H, default 16, glyph height in pixels.
REQ-008 The block SHALL have parameter CODEW, default 8, glyph code width.
REQ-009 The block SHALL have parameter FONT_COUNT, default 128, glyphs in font ROM.
REQ-010 The block SHALL have parameter TRAM_LAT, default 1, tram read latency in cycles.
REQ-011 The block SHALL have parameter FONT_LAT, default 1, font read latency in cycles.
REQ-012 The block SHALL have parameter BLINK_FRAMES, default 32, frames per blink half-period.
REQ-013 Ports SHALL be, in order:
clk_pix  in  1  pixel clock, the only clock.
rst_pix_n  in  1  reset, asynchronous, active-low.
start  in  1  one-cycle frame-start pulse.
dx, dy  in  CORDW each  signed display position.
text_hres, text_vres  in  CORDW each  text area in characters.
scale_x, scale_y  in  4 each  integer pixel scale per axis.
scroll_offs  in  ADDRW  tram index of the top-left character.
cursor_en  in  1  cursor enable.
cursor_addr  in  ADDRW  tram index of the cursor.
tram_addr  out  ADDRW  tram read address.
tram_data  in  WORD  tram read data.
font_addr  out  ADDRW+4  font ROM row address.
font_data  in  GLYPH_W  font ROM row, MSB leftmost.
pix  out  CIDXW  colour index.
paint  out  1  pixel is opaque text.

Function
REQ-014 Tram word fields SHALL be: code [CODEW-1:0]; fg [CODEW+:CIDXW]; bg [CODEW+CIDXW+:CIDXW]; blink bit WORD-1; transparent-bg bit WORD-2.
REQ-015 A scale of 0 SHALL be treated as 1.
REQ-016 The text area SHALL be 0<=dx<text_hres*GLYPH_W*sx and 0<=dy<text_vres*GLYPH_H*sy.
REQ-017 Within the text area the block SHALL compute: col=dx/(GLYPH_W*sx); row=dy/(GLYPH_H*sy); gx=(dx/sx)%GLYPH_W; gy=(dy/sy)%GLYPH_H.
REQ-018 The character index SHALL be i=(scroll_offs+row*text_hres+col) mod TRAM_DEPTH, wrapping past the last word to 0.
REQ-019 The pipeline SHALL be as follows, where t is the cycle dx/dy are presented.
- tram_addr=i registered at t+1.
- font_addr=code*GLYPH_H+gy registered at t+2+TRAM_LAT.
- pix/paint registered at t+3+TRAM_LAT+FONT_LAT (LAT=5 at defaults).
REQ-020 fg, bg, attributes, gx and the cursor match SHALL be delayed alongside the data they belong to.
REQ-021 A code >= FONT_COUNT SHALL use glyph 0.
REQ-022 The glyph bit SHALL be font_data[GLYPH_W-1-gx]; bit=1 selects fg and bit=0 selects bg.
REQ-023 Blink: a frame counter SHALL increment on each start and wrap at BLINK_FRAMES-1; the phase bit SHALL toggle on that wrap.
REQ-024 When the phase bit is 0, characters with the blink bit set SHALL show bg for all pixels.
REQ-025 Cursor: if cursor_en, i==cursor_addr and the phase bit is 1, fg and bg SHALL be swapped after blink is applied.
REQ-026 Transparent-bg: if the attribute is set and the selected colour is bg, paint SHALL be 0.
REQ-027 In all other text-area cases paint SHALL be 1.
REQ-028 Outside the text area, including negative coordinates, pix and paint SHALL be 0.
REQ-029 Outside the text area, tram_addr and font_addr SHALL hold their values.
REQ-030 Configuration inputs SHALL be sampled every cycle; changes take effect at the pixel presented in the same cycle.
REQ-031 Per-pixel behaviour SHALL be continuous, with no stall or backpressure.

Reset
REQ-032 While rst_pix_n=0, tram_addr, font_addr, pix, paint and the frame counter SHALL be 0, the phase bit SHALL be 1, and all pipeline stages SHALL be cleared.
REQ-033 Reset assertion mid-frame SHALL take effect immediately.
REQ-034 Output SHALL be valid LAT cycles after the first in-area pixel following reset release.

Verification
REQ-035 Scenario: defaults, scale 1, scroll 0, tram[0]=code 0x41 fg=0xF bg=0x1, glyph row 0=0x80, dx=dy=0 -> after 5 cycles pix=0xF, paint=1; at dx=1, pix=0x1.
REQ-036 Scenario: scroll_offs=2010, text_hres=84, dx=8*7, dy=0 -> tram_addr=(2010+7) mod 2016=1.
REQ-037 Scenario: scale_x=scale_y=2 -> dx=0..15 map to col 0 with gx=dx/2; dx=16 -> tram_addr=1; dy=32 -> row 1 (tram_addr=84 at dx=0).
REQ-038 Scenario: cursor_en=1, cursor_addr=0, 32 start pulses -> fg/bg swapped on the first frame, normal on frames 32-63, swapped again on frame 64; blink-attribute char shows bg only on frames 32-63.
REQ-039 Scenario: transparent-bg char on a glyph bit 0 pixel -> paint=0; dx=-1 or dx=text_hres*8 -> pix=0, paint=0.
REQ-040 Scenario: rst_pix_n low mid-line -> all outputs 0 asynchronously; after release the phase bit is 1 and the frame counter is 0.

Source files
------------

// File: rtl/textmode_attr.sv
// Attributed text-mode pixel renderer: maps a display position to a tram cell and glyph
// row, then colours the pixel from the cell's fg/bg, blink, cursor and transparency bits.
module textmode_attr #(
  parameter int CORDW        = 16,
  parameter int WORD         = 32,
  parameter int ADDRW        = 11,
  parameter int TRAM_DEPTH   = 2016,
  parameter int CIDXW        = 4,
  parameter int GLYPH_W      = 8,
  parameter int GLYPH_H      = 16,
  parameter int CODEW        = 8,
  parameter int FONT_COUNT   = 128,
  parameter int TRAM_LAT     = 1,
  parameter int FONT_LAT     = 1,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                    clk_pix,
  input  logic                    rst_pix_n,
  input  logic                    start,
  input  logic signed [CORDW-1:0] dx,
  input  logic signed [CORDW-1:0] dy,
  input  logic signed [CORDW-1:0] text_hres,
  input  logic signed [CORDW-1:0] text_vres,
  input  logic [3:0]              scale_x,
  input  logic [3:0]              scale_y,
  input  logic [ADDRW-1:0]        scroll_offs,
  input  logic                    cursor_en,
  input  logic [ADDRW-1:0]        cursor_addr,
  output logic [ADDRW-1:0]        tram_addr,
  input  logic [WORD-1:0]         tram_data,
  output logic [ADDRW+3:0]        font_addr,
  input  logic [GLYPH_W-1:0]      font_data,
  output logic [CIDXW-1:0]        pix,
  output logic                    paint
);
  localparam int EW  = CORDW + 8;
  localparam int IW  = 2 * EW;
  localparam int FAW = ADDRW + 4;
  localparam int CW1 = CODEW + 1;
  localparam int GXW = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
  localparam int GYW = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
  localparam int FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CODEW:0] FONT_LIM = CW1'(FONT_COUNT);

  typedef struct packed {
    logic           vld;
    logic           cur;
    logic [GXW-1:0] gx;
    logic [GYW-1:0] gy;
  } s1_t;

  typedef struct packed {
    logic             vld;
    logic             cur;
    logic             blink;
    logic             transp;
    logic [GXW-1:0]   gx;
    logic [CIDXW-1:0] fg;
    logic [CIDXW-1:0] bg;
  } s2_t;

  // Stage 0: position -> cell index, glyph coordinates
  logic [3:0]    sx, sy;
  logic [EW-1:0] dx_u, dy_u, cell_w, cell_h, col, row;
  logic [IW-1:0] idx_full;
  logic          in_area;
  logic [ADDRW-1:0] idx;
  s1_t           s1_d;

  assign sx     = (scale_x == 4'd0) ? 4'd1 : scale_x;
  assign sy     = (scale_y == 4'd0) ? 4'd1 : scale_y;
  assign dx_u   = EW'($unsigned(dx));
  assign dy_u   = EW'($unsigned(dy));
  assign cell_w = EW'(GLYPH_W) * EW'(sx);
  assign cell_h = EW'(GLYPH_H) * EW'(sy);
  assign col    = dx_u / cell_w;
  assign row    = dy_u / cell_h;
  assign in_area = !dx[CORDW-1] && !dy[CORDW-1]
                && (dx_u < EW'($unsigned(text_hres)) * cell_w)
                && (dy_u < EW'($unsigned(text_vres)) * cell_h);
  assign idx_full = IW'(scroll_offs) + IW'(row) * IW'($unsigned(text_hres)) + IW'(col);
  assign idx      = ADDRW'(idx_full % IW'(TRAM_DEPTH));

  assign s1_d.vld = in_area;
  assign s1_d.cur = cursor_en && (idx == cursor_addr);
  assign s1_d.gx  = GXW'((dx_u / EW'(sx)) % EW'(GLYPH_W));
  assign s1_d.gy  = GYW'((dy_u / EW'(sy)) % EW'(GLYPH_H));

  logic [ADDRW-1:0] tram_addr_q;
  s1_t              s1_q [TRAM_LAT+1];

  // NOTE: sequential state uses non-blocking assignments so each slot takes its predecessor's old value.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      tram_addr_q <= '0;
      for (int k = 0; k <= TRAM_LAT; k++) s1_q[k] <= '0;
    end else begin
      if (in_area) tram_addr_q <= idx;
      s1_q[0] <= s1_d;
      for (int k = 1; k <= TRAM_LAT; k++) s1_q[k] <= s1_q[k-1];
    end
  end

  // Stage 2: tram word -> font row address; attributes follow the pixel
  s1_t              t1;
  logic [CODEW-1:0] code, glyph;
  logic [FAW-1:0]   font_addr_d, font_addr_q;
  s2_t              s2_d;
  s2_t              s2_q [FONT_LAT+1];

  assign t1 = s1_q[TRAM_LAT];

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    code        = tram_data[CODEW-1:0];
    glyph       = ({1'b0, code} >= FONT_LIM) ? '0 : code;
    font_addr_d = font_addr_q;
    if (t1.vld) font_addr_d = FAW'(glyph) * FAW'(GLYPH_H) + FAW'(t1.gy);
    s2_d        = '0;
    s2_d.vld    = t1.vld;
    s2_d.cur    = t1.cur;
    s2_d.gx     = t1.gx;
    s2_d.blink  = tram_data[WORD-1];
    s2_d.transp = tram_data[WORD-2];
    s2_d.fg     = tram_data[CODEW +: CIDXW];
    s2_d.bg     = tram_data[CODEW+CIDXW +: CIDXW];
  end

  // Stage 3: glyph bit -> colour, with blink, cursor swap and transparency
  s2_t              t2;
  logic             glyph_bit, sel_fg;
  logic [CIDXW-1:0] fg_c, bg_c, pix_d, pix_q;
  logic             paint_d, paint_q;
  logic [FCW-1:0]   frame_d, frame_q;
  logic             phase_d, phase_q;

  assign t2 = s2_q[FONT_LAT];

  always_comb begin
    glyph_bit = font_data[GXW'(GLYPH_W-1) - t2.gx];
    sel_fg    = glyph_bit && !(t2.blink && !phase_q);
    fg_c      = t2.fg;
    bg_c      = t2.bg;
    if (t2.cur && phase_q) begin
      fg_c = t2.bg;
      bg_c = t2.fg;
    end
    pix_d   = '0;
    paint_d = 1'b0;
    if (t2.vld) begin
      pix_d   = sel_fg ? fg_c : bg_c;
      paint_d = sel_fg || !t2.transp;
    end
  end

  always_comb begin
    frame_d = frame_q;
    phase_d = phase_q;
    if (start) begin
      if (frame_q == FCW'(BLINK_FRAMES - 1)) begin
        frame_d = '0;
        phase_d = ~phase_q;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      font_addr_q <= '0;
      pix_q       <= '0;
      paint_q     <= 1'b0;
      frame_q     <= '0;
      phase_q     <= 1'b1;
      for (int k = 0; k <= FONT_LAT; k++) s2_q[k] <= '0;
    end else begin
      font_addr_q <= font_addr_d;
      pix_q       <= pix_d;
      paint_q     <= paint_d;
      frame_q     <= frame_d;
      phase_q     <= phase_d;
      s2_q[0]     <= s2_d;
      for (int k = 1; k <= FONT_LAT; k++) s2_q[k] <= s2_q[k-1];
    end
  end

  // Reserved tram bits between the fields are intentionally ignored
  logic unused_tram;
  assign unused_tram = ^tram_data;

  assign tram_addr = tram_addr_q;
  assign font_addr = font_addr_q;
  assign pix       = pix_q;
  assign paint     = paint_q;
endmodule

// File: tb/tb_textmode_attr.sv
// Directed bench for textmode_attr at default parameters: vector table plus hand-written
// latency, blink/cursor frame and mid-line reset sequences.
module tb_textmode_attr;
  logic               clk_pix     = 1'b0;
  logic               rst_pix_n   = 1'b0;
  logic               start       = 1'b0;
  logic signed [15:0] dx          = '0;
  logic signed [15:0] dy          = '0;
  logic signed [15:0] text_hres   = 16'sd84;
  logic signed [15:0] text_vres   = 16'sd24;
  logic [3:0]         scale_x     = 4'd1;
  logic [3:0]         scale_y     = 4'd1;
  logic [10:0]        scroll_offs = '0;
  logic               cursor_en   = 1'b0;
  logic [10:0]        cursor_addr = '0;
  logic [10:0]        tram_addr;
  logic [31:0]        tram_data;
  logic [14:0]        font_addr;
  logic [7:0]         font_data;
  logic [3:0]         pix;
  logic               paint;

  logic [31:0] tram [2048];
  logic [7:0]  font [32768];

  int n_tests = 0;
  int n_fail  = 0;

  textmode_attr dut (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .start(start),
    .dx(dx), .dy(dy), .text_hres(text_hres), .text_vres(text_vres),
    .scale_x(scale_x), .scale_y(scale_y), .scroll_offs(scroll_offs),
    .cursor_en(cursor_en), .cursor_addr(cursor_addr),
    .tram_addr(tram_addr), .tram_data(tram_data),
    .font_addr(font_addr), .font_data(font_data),
    .pix(pix), .paint(paint)
  );

  always #5 clk_pix = ~clk_pix;

  // Synchronous memories with one cycle of read latency
  always @(posedge clk_pix) begin
    tram_data <= tram[tram_addr];
    font_data <= font[font_addr];
  end

  typedef struct {
    string       name;
    int          x;
    int          y;
    logic [3:0]  s;
    logic [10:0] scroll;
    logic        cen;
    logic [10:0] ta;
    logic        chk_pix;
    logic [3:0]  pix;
    logic        paint;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, int x, int y, logic [3:0] s, logic [10:0] scroll,
                              logic cen, logic [10:0] ta, logic chk_pix, logic [3:0] p,
                              logic pt);
    vec_t v;
    v.name = name; v.x = x; v.y = y; v.s = s; v.scroll = scroll; v.cen = cen;
    v.ta = ta; v.chk_pix = chk_pix; v.pix = p; v.paint = pt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_pix);
    @(negedge clk_pix);
  endtask

  task automatic set_pos(input int x, input int y, input logic [3:0] s, input logic [10:0] scroll,
                         input logic cen);
    dx = 16'(x); dy = 16'(y);
    scale_x = s; scale_y = s;
    scroll_offs = scroll; cursor_en = cen; cursor_addr = '0;
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk_pix);
    set_pos(v.x, v.y, v.s, v.scroll, v.cen);
    tick(1);
    check({v.name, "/tram_addr"}, 32'(tram_addr), 32'(v.ta));
    tick(4);
    if (v.chk_pix) check({v.name, "/pix"}, 32'(pix), 32'(v.pix));
    check({v.name, "/paint"}, 32'(paint), 32'(v.paint));
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_pix); start = 1'b1;
      @(negedge clk_pix); start = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    foreach (tram[i]) tram[i] = '0;
    foreach (font[i]) font[i] = '0;
    tram[0]  = 32'h0000_1F41;  // 'A' fg F bg 1
    tram[1]  = 32'h0000_3242;  // fg 2 bg 3
    tram[2]  = 32'h0000_76C1;  // code past font end, fg 6 bg 7
    tram[3]  = 32'h4000_9841;  // transparent bg, fg 8 bg 9
    tram[4]  = 32'h8000_BA41;  // blink, fg A bg B
    tram[84] = 32'h0000_5443;  // fg 4 bg 5
    font[12'h410] = 8'h80; font[12'h411] = 8'h40;
    font[12'h420] = 8'hFF; font[12'h421] = 8'hFF;
    font[12'h430] = 8'h00;
    font[0] = 8'hF0; font[15] = 8'h80;

    //           name             x    y    s  scroll cen  ta   chk pix paint
    vecs.push_back(mk("basic_fg",      0,   0, 1,    0, 0,    0, 1, 4'hF, 1));
    vecs.push_back(mk("basic_bg",      1,   0, 1,    0, 0,    0, 1, 4'h1, 1));
    vecs.push_back(mk("scroll_wrap",  56,   0, 1, 2010, 0,    1, 1, 4'h2, 1));
    vecs.push_back(mk("scale2_gx0",    1,   0, 2,    0, 0,    0, 1, 4'hF, 1));
    vecs.push_back(mk("scale2_gx1",    2,   0, 2,    0, 0,    0, 1, 4'h1, 1));
    vecs.push_back(mk("scale2_col1",  16,   0, 2,    0, 0,    1, 1, 4'h2, 1));
    vecs.push_back(mk("scale2_row1",   0,  32, 2,    0, 0,   84, 1, 4'h5, 1));
    vecs.push_back(mk("scale2_gy1",    2,   2, 2,    0, 0,    0, 1, 4'hF, 1));
    vecs.push_back(mk("scale0_as_1",   8,   1, 0,    0, 0,    1, 1, 4'h2, 1));
    vecs.push_back(mk("clamp_fg",     16,   0, 1,    0, 0,    2, 1, 4'h6, 1));
    vecs.push_back(mk("clamp_bg",     20,   0, 1,    0, 0,    2, 1, 4'h7, 1));
    vecs.push_back(mk("transp_fg",    24,   0, 1,    0, 0,    3, 1, 4'h8, 1));
    vecs.push_back(mk("transp_bg",    25,   0, 1,    0, 0,    3, 0, 4'h0, 0));
    vecs.push_back(mk("out_neg",      -1,   0, 1,    0, 0,    3, 1, 4'h0, 0));
    vecs.push_back(mk("out_right",   672,   0, 1,    0, 0,    3, 1, 4'h0, 0));
    vecs.push_back(mk("out_bottom",    0, 384, 1,    0, 0,    3, 1, 4'h0, 0));
    vecs.push_back(mk("last_col",    671,   0, 1,    0, 0,   83, 1, 4'h0, 1));
    vecs.push_back(mk("last_row",      0, 383, 1,    0, 0, 1932, 1, 4'h0, 1));
    vecs.push_back(mk("blink_shown",  32,   0, 1,    0, 0,    4, 1, 4'hA, 1));
    vecs.push_back(mk("cursor_fgbit",  0,   0, 1,    0, 1,    0, 1, 4'h1, 1));
    vecs.push_back(mk("cursor_bgbit",  1,   0, 1,    0, 1,    0, 1, 4'hF, 1));
    vecs.push_back(mk("cursor_other",  8,   0, 1,    0, 1,    1, 1, 4'h2, 1));

    // Reset state
    tick(2);
    check("reset/tram_addr", 32'(tram_addr), 32'd0);
    check("reset/font_addr", 32'(font_addr), 32'd0);
    check("reset/pix",       32'(pix),       32'd0);
    check("reset/paint",     32'(paint),     32'd0);
    rst_pix_n = 1'b1;

    foreach (vecs[i]) apply(vecs[i]);

    // Exact latency: one in-area pixel between outside pixels and the next pixel
    @(negedge clk_pix);
    set_pos(-1, 0, 1, 0, 0);
    tick(8);
    dx = 16'sd0;
    tick(1);
    dx = 16'sd1;
    tick(3);
    check("lat/edge4_paint", 32'(paint), 32'd0);
    tick(1);
    check("lat/edge5_pix",   32'(pix),   32'hF);
    check("lat/edge5_paint", 32'(paint), 32'd1);
    tick(1);
    check("lat/edge6_pix",   32'(pix),   32'h1);

    // Blink/cursor phase across frames
    pulses(32);
    apply(mk("f32_cursor_off",  0, 0, 1, 0, 1, 0, 1, 4'hF, 1));
    apply(mk("f32_blink_fg",   32, 0, 1, 0, 1, 4, 1, 4'hB, 1));
    apply(mk("f32_blink_bg",   33, 0, 1, 0, 1, 4, 1, 4'hB, 1));
    pulses(31);
    apply(mk("f63_cursor_off",  0, 0, 1, 0, 1, 0, 1, 4'hF, 1));
    pulses(1);
    apply(mk("f64_cursor_on",   0, 0, 1, 0, 1, 0, 1, 4'h1, 1));
    apply(mk("f64_blink_shown",32, 0, 1, 0, 1, 4, 1, 4'hA, 1));

    // Mid-line asynchronous reset, then counter/phase restart
    apply(mk("pre_reset", 56, 0, 1, 2010, 0, 1, 1, 4'h2, 1));
    pulses(5);
    @(negedge clk_pix);
    #2 rst_pix_n = 1'b0;
    #1;
    check("midrst/tram_addr", 32'(tram_addr), 32'd0);
    check("midrst/font_addr", 32'(font_addr), 32'd0);
    check("midrst/pix",       32'(pix),       32'd0);
    check("midrst/paint",     32'(paint),     32'd0);
    @(negedge clk_pix);
    rst_pix_n = 1'b1;
    apply(mk("post_rst_phase1", 0, 0, 1, 0, 1, 0, 1, 4'h1, 1));
    pulses(31);
    apply(mk("post_rst_f31",    0, 0, 1, 0, 1, 0, 1, 4'h1, 1));
    pulses(1);
    apply(mk("post_rst_f32",    0, 0, 1, 0, 1, 0, 1, 4'hF, 1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
